// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the communication-bus receive path.
//   FRAME_W : total serial frame length (payload followed by CRC remainder)
//   DATA_W  : payload width, occupying frame[FRAME_W-1:CRC_W]
//   CRC_W   : width of the CRC remainder / checker error result
//   TIMEOUT : default idle-cycle limit for the optional inter-bit timeout
//   rx_state_e : deframer state encoding
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int FRAME_W = 67;
    localparam int DATA_W  = 64;
    localparam int CRC_W   = 3;
    localparam int TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/bus_rx_timer.sv
// -----------------------------------------------------------------------------
// bus_rx_timer
// Inter-bit idle counter for the receive deframer. Counts consecutive idle
// cycles while the deframer is collecting a frame and flags expiry on the
// TIMEOUT-th idle cycle, so the abort happens in that same cycle.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : restart counting from zero (bit accepted or not collecting)
//   tick    : one idle cycle elapsed
//   expired : combinational, high on the cycle that reaches TIMEOUT
// -----------------------------------------------------------------------------
module bus_rx_timer #(
    parameter int TIMEOUT = bus_pkg::TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt_reg;

    // The counter holds the number of idle cycles already seen, so the
    // TIMEOUT-th idle cycle is the one where it still reads TIMEOUT-1.
    assign expired = tick && !clear && (idle_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (clear || expired) begin
            idle_cnt_reg <= '0;
        end else if (tick) begin
            idle_cnt_reg <= idle_cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/bus_rx_deframer.sv
// -----------------------------------------------------------------------------
// bus_rx_deframer
// Serial receive deframer. Shifts in a FRAME_W-bit frame MSB first, presents
// it to the external CRC checker for one cycle, registers the checker result
// and hands the payload plus a CRC-error flag to the consumer over
// valid/ready.
//
// Optional feature: define BUS_RX_TIMEOUT_EN to abort a partially received
// frame after TIMEOUT idle cycles between bits (timeout_o pulses). Without
// the macro the block waits indefinitely for the next bit and timeout_o is 0.
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   rx_bit_i        : serial data bit
//   rx_bit_valid_i  : rx_bit_i valid this cycle
//   rx_sof_i        : current valid bit is the frame MSB
//   frame_o         : raw shift register, feeds checker data_in
//   chk_en_o        : one-cycle checker enable
//   chk_error_i     : checker remainder, nonzero = error
//   data_o          : payload, frame[FRAME_W-1:CRC_W]
//   valid_o/ready_i : payload handshake
//   crc_err_o       : OR of the registered checker result, valid with valid_o
//   overrun_o       : one-cycle pulse when an incoming bit is dropped
//   timeout_o       : one-cycle pulse when a partial frame is aborted
// -----------------------------------------------------------------------------
module bus_rx_deframer #(
    parameter int FRAME_W = bus_pkg::FRAME_W,
    parameter int DATA_W  = bus_pkg::DATA_W,
    parameter int CRC_W   = bus_pkg::CRC_W,
    parameter int TIMEOUT = bus_pkg::TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_bit_i,
    input  logic               rx_bit_valid_i,
    input  logic               rx_sof_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               chk_en_o,
    input  logic [CRC_W-1:0]   chk_error_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               crc_err_o,
    output logic               overrun_o,
    output logic               timeout_o
);

    import bus_pkg::*;

    localparam int CNT_BITS = $clog2(FRAME_W + 1);

    rx_state_e            state_reg, state_next;
    logic [FRAME_W-1:0]   shift_reg, shift_next;
    logic [CNT_BITS-1:0]  count_reg, count_next;
    logic [CRC_W-1:0]     err_reg,   err_next;
    logic [FRAME_W-1:0]   first_bit;
    logic                 timer_expired;

    // A start-of-frame bit replaces whatever was collected so far; after the
    // remaining FRAME_W-1 shifts it ends up in the MSB position.
    assign first_bit = {{(FRAME_W-1){1'b0}}, rx_bit_i};

`ifdef BUS_RX_TIMEOUT_EN
    logic idle_tick;
    logic idle_clear;

    // Only idle cycles inside a frame count; any bit, or being outside
    // SHIFT, restarts the count. A bit in the expiry cycle therefore wins.
    assign idle_tick  = (state_reg == SHIFT) && !rx_bit_valid_i;
    assign idle_clear = !idle_tick;

    bus_rx_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (idle_clear),
        .tick    (idle_tick),
        .expired (timer_expired)
    );
`else
    // No idle timer in this build: a negative limit is the only value that
    // could never be configured, so this is constant-false.
    assign timer_expired = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        err_next   = err_reg;
        chk_en_o   = 1'b0;
        valid_o    = 1'b0;
        overrun_o  = 1'b0;
        timeout_o  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Bits without SOF are line noise between frames.
                if (rx_bit_valid_i && rx_sof_i) begin
                    shift_next = first_bit;
                    count_next = CNT_BITS'(1);
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (rx_bit_valid_i) begin
                    if (rx_sof_i) begin
                        shift_next = first_bit;
                        count_next = CNT_BITS'(1);
                    end else begin
                        shift_next = {shift_reg[FRAME_W-2:0], rx_bit_i};
                        count_next = count_reg + CNT_BITS'(1);
                        if (count_reg == CNT_BITS'(FRAME_W - 1)) begin
                            state_next = CHECK;
                        end
                    end
                end else if (timer_expired) begin
                    shift_next = '0;
                    count_next = '0;
                    state_next = IDLE;
                    timeout_o  = 1'b1;
                end
            end

            CHECK: begin
                chk_en_o   = 1'b1;
                err_next   = chk_error_i;
                overrun_o  = rx_bit_valid_i;
                state_next = OUT;
            end

            OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    // The handshake cycle behaves like IDLE for the incoming
                    // bit, which lets frames run back to back.
                    if (rx_bit_valid_i && rx_sof_i) begin
                        shift_next = first_bit;
                        count_next = CNT_BITS'(1);
                        state_next = SHIFT;
                    end else begin
                        count_next = '0;
                        state_next = IDLE;
                    end
                end else begin
                    overrun_o = rx_bit_valid_i;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign frame_o   = shift_reg;
    assign data_o    = shift_reg[FRAME_W-1 -: DATA_W];
    assign crc_err_o = valid_o & (|err_reg);

endmodule
